// File: rtl/ldpc_code_packer.sv
// Buffers 12-bit LDPC codewords and serialises each into two UART bytes.
// High byte carries the sync nibble; low byte follows, never interleaved.
module ldpc_code_packer #(
    parameter int         DEPTH = 4,
    parameter logic [3:0] HDR   = 4'hA
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [11:0]                    code,
    input  logic                           tx_en,
    input  logic                           uart_tx_busy,
    output logic                           uart_tx_start,
    output logic [7:0]                     uart_tx_data,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic                           fifo_full,
    output logic                           overflow,
    output logic                           busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HI,
        S_GUARD_HI,
        S_WAIT_HI,
        S_SEND_LO,
        S_GUARD_LO,
        S_WAIT_LO
    } state_t;

    state_t        r_state;
    logic [11:0]   r_mem [DEPTH];
    logic [11:0]   r_word;
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_ovf;
    logic          r_busy;
    logic          r_start;
    logic [7:0]    r_data;

    logic          w_pop;
    logic          w_push;
    logic          w_active_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_push = tx_en && (!r_full || w_pop);

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_count - 1'b1;
        end
    end

    // Whether the FSM will be outside IDLE after this edge.
    always_comb begin
        w_active_nxt = 1'b1;
        case (r_state)
            S_IDLE:    w_active_nxt = w_pop;
            S_WAIT_LO: w_active_nxt = uart_tx_busy;
            default:   w_active_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (tx_en && !w_push) begin
                r_ovf <= 1'b1;
            end
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == FULL_CNT);
            r_busy  <= w_active_nxt || (w_cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_start <= 1'b0;
            r_data  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_word  <= r_mem[r_rd];
                        r_state <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    if (!uart_tx_busy) begin
                        r_data  <= {HDR, r_word[11:8]};
                        r_start <= 1'b1;
                        r_state <= S_GUARD_HI;
                    end
                end
                S_GUARD_HI: r_state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (!uart_tx_busy) begin
                        r_state <= S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    if (!uart_tx_busy) begin
                        r_data  <= r_word[7:0];
                        r_start <= 1'b1;
                        r_state <= S_GUARD_LO;
                    end
                end
                S_GUARD_LO: r_state <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uart_tx_start = r_start;
    assign uart_tx_data  = r_data;
    assign fifo_count    = r_count;
    assign fifo_full     = r_full;
    assign overflow      = r_ovf;
    assign busy          = r_busy;

endmodule

// File: tb/tb_ldpc_code_packer.sv
// Directed bench for ldpc_code_packer with a simple UART busy model.
// Bytes are logged on every start pulse and compared to hand-built lists.
module tb_ldpc_code_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] code = '0;
    logic        tx_en = 1'b0;
    logic        uart_tx_busy;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;
    logic        busy;

    logic        force_busy = 1'b0;
    int          m_len = 10;
    int          m_cnt;
    logic [7:0]  bytes [$];
    int          pulses = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    ldpc_code_packer #(.DEPTH(DEPTH), .HDR(4'hA)) dut (
        .clk           (clk),
        .rst           (rst),
        .code          (code),
        .tx_en         (tx_en),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #10 clk = ~clk;

    // Busy rises the cycle after a start pulse and holds for m_len cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= 0;
        else if (uart_tx_start) m_cnt <= m_len;
        else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end

    assign uart_tx_busy = force_busy | (m_cnt != 0);

    always @(negedge clk) begin
        if (uart_tx_start) begin
            bytes.push_back(uart_tx_data);
            pulses++;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(int i);
        if (i < bytes.size()) return {24'h0, bytes[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(logic [11:0] c);
        code  = c;
        tx_en = 1'b1;
        tick();
        tx_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_pulses(int n, int budget);
        int t = 0;
        while (pulses < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    task automatic wait_idle(string tag, int budget);
        int t = 0;
        while ((busy || uart_tx_busy) && t < budget) begin
            tick();
            t++;
        end
        chk(tag, {31'h0, busy}, 32'h0);
    endtask

    int          base;
    int          qb;
    int          lat;
    int          t;
    int          idx;
    logic [11:0] words [12];

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_start", {31'h0, uart_tx_start}, 0);
        chk("rst_data",  {24'h0, uart_tx_data}, 0);
        chk("rst_count", {29'h0, fifo_count}, 0);
        chk("rst_full",  {31'h0, fifo_full}, 0);
        chk("rst_ovf",   {31'h0, overflow}, 0);
        chk("rst_busy",  {31'h0, busy}, 0);
        rst = 1'b0;
        tick();

        // single codeword, latency and byte split
        m_len = 10;
        base = pulses;
        qb = bytes.size();
        code = 12'h5A3;
        tx_en = 1'b1;
        tick();
        tx_en = 1'b0;
        chk("t1_count", {29'h0, fifo_count}, 1);
        lat = 1;
        while (!uart_tx_start && lat < 20) begin
            tick();
            lat++;
        end
        chk("t1_latency", lat, 3);
        wait_idle("t1_idle", 200);
        chk("t1_pulses", pulses - base, 2);
        chk("t1_b0", byte_at(qb), 32'hA5);
        chk("t1_b1", byte_at(qb + 1), 32'hA3);

        // stalled UART: fill, then drop one
        do_reset();
        force_busy = 1'b1;
        m_len = 3;
        base = pulses;
        qb = bytes.size();
        for (int i = 1; i <= 4; i++) push(12'(i));
        chk("t2_count4", {29'h0, fifo_count}, 3);
        chk("t2_full4",  {31'h0, fifo_full}, 0);
        push(12'h005);
        chk("t2_count5", {29'h0, fifo_count}, 4);
        chk("t2_full5",  {31'h0, fifo_full}, 1);
        chk("t2_ovf5",   {31'h0, overflow}, 0);
        push(12'h006);
        chk("t2_count6", {29'h0, fifo_count}, 4);
        chk("t2_ovf6",   {31'h0, overflow}, 1);
        force_busy = 1'b0;
        wait_idle("t2_idle", 500);
        chk("t2_pulses", pulses - base, 10);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hi", byte_at(qb + 2 * i), 32'hA0);
            chk("t2_lo", byte_at(qb + 2 * i + 1), 32'(i + 1));
        end
        chk("t2_ovf_sticky", {31'h0, overflow}, 1);
        chk("t2_count_end", {29'h0, fifo_count}, 0);

        // push coinciding with pop while full
        do_reset();
        force_busy = 1'b1;
        m_len = 10;
        base = pulses;
        qb = bytes.size();
        for (int i = 1; i <= 5; i++) push(12'h800 + 12'(i));
        chk("t3_full", {31'h0, fifo_full}, 1);
        force_busy = 1'b0;
        wait_pulses(base + 2, 200);
        chk("t3_lo_sent", pulses - base, 2);
        t = 0;
        while (!uart_tx_busy && t < 50) begin
            tick();
            t++;
        end
        while (uart_tx_busy && t < 50) begin
            tick();
            t++;
        end
        tick();
        chk("t3_pre_count", {29'h0, fifo_count}, 4);
        push(12'h7E1);
        chk("t3_count", {29'h0, fifo_count}, 4);
        chk("t3_full2", {31'h0, fifo_full}, 1);
        chk("t3_ovf",   {31'h0, overflow}, 0);
        wait_idle("t3_idle", 1000);
        chk("t3_pulses", pulses - base, 12);
        chk("t3_last_hi", byte_at(qb + 10), 32'hA7);
        chk("t3_last_lo", byte_at(qb + 11), 32'hE1);

        // UART busy held at SEND_HI entry
        do_reset();
        force_busy = 1'b1;
        m_len = 10;
        base = pulses;
        push(12'h3C7);
        repeat (20) tick();
        chk("t4_no_pulse", pulses - base, 0);
        chk("t4_data", {24'h0, uart_tx_data}, 0);
        chk("t4_busy", {31'h0, busy}, 1);
        force_busy = 1'b0;
        repeat (6) tick();
        chk("t4_one_pulse", pulses - base, 1);
        chk("t4_data_hi", {24'h0, uart_tx_data}, 32'hA3);
        wait_idle("t4_idle", 300);

        // async reset between the two bytes
        do_reset();
        m_len = 10;
        base = pulses;
        push(12'h5A3);
        wait_pulses(base + 1, 50);
        repeat (3) tick();
        chk("t5_pre_data", {24'h0, uart_tx_data}, 32'hA5);
        #3 rst = 1'b1;
        #1;
        chk("t5_start", {31'h0, uart_tx_start}, 0);
        chk("t5_data",  {24'h0, uart_tx_data}, 0);
        chk("t5_busy",  {31'h0, busy}, 0);
        chk("t5_count", {29'h0, fifo_count}, 0);
        tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("t5_no_lo", pulses - base, 1);
        chk("t5_count_end", {29'h0, fifo_count}, 0);
        chk("t5_busy_end", {31'h0, busy}, 0);

        // pointer wrap with a fast UART
        do_reset();
        m_len = 2;
        base = pulses;
        qb = bytes.size();
        for (int i = 0; i < 12; i++) words[i] = 12'(i * 12'h111 + 1);
        idx = 0;
        t = 0;
        while (idx < 12 && t < 2000) begin
            if (!fifo_full) begin
                code = words[idx];
                tx_en = 1'b1;
                idx++;
            end else begin
                tx_en = 1'b0;
            end
            tick();
            t++;
        end
        tx_en = 1'b0;
        chk("t6_fed", idx, 12);
        wait_idle("t6_idle", 2000);
        chk("t6_pulses", pulses - base, 24);
        for (int i = 0; i < 12; i++) begin
            chk("t6_hi", byte_at(qb + 2 * i), {24'h0, 4'hA, words[i][11:8]});
            chk("t6_lo", byte_at(qb + 2 * i + 1), {24'h0, words[i][7:0]});
        end
        chk("t6_ovf", {31'h0, overflow}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
